obstacle_line_locator: RTL and testbench

Producer side of the obstacle pixel path. Holds the obstacle table, and during each horizontal blank scans it for the obstacles crossing the next scanline. During active video it emits per pixel the obstacle hit flag, id, ROM-local coordinates and absolute position. Its outputs drive `obstacle_display_controller`, which maps them to RGB.

---
 rtl/obstacle_line_locator.sv | 183 ++++++++++++++++++
 tb/tb_obstacle_line_locator.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/obstacle_line_locator.sv
// Obstacle table plus per-scanline slot capture; pixel outputs are registered with 1-cycle latency.
// READY follows line_start by OBSTACLE_NUM+1 cycles; there is no backpressure, blanking must cover the scan.
module obstacle_line_locator #(
  parameter int OBSTACLE_NUM    = 7,
  parameter int OBSTACLE_WIDTH  = 10,
  parameter int BLOCK_LEN_WIDTH = 4,
  parameter int SCREEN_WIDTH    = 10,
  parameter int PHY_WIDTH       = 15,
  parameter int LINE_SLOTS      = 4
) (
  input  logic                               sys_clk,
  input  logic                               sys_rst,
  input  logic                               wr_en,
  input  logic [$clog2(OBSTACLE_NUM)-1:0]    wr_idx,
  input  logic                               wr_valid,
  input  logic [PHY_WIDTH-1:0]               wr_abs_x,
  input  logic [PHY_WIDTH-1:0]               wr_abs_y,
  input  logic [BLOCK_LEN_WIDTH-1:0]         wr_len,
  input  logic [PHY_WIDTH-1:0]               camera_y,
  input  logic                               line_start,
  input  logic [SCREEN_WIDTH-1:0]            next_line,
  input  logic [SCREEN_WIDTH-1:0]            pixel_x,
  input  logic                               pixel_active,
  output logic                               obstacle_on,
  output logic [$clog2(OBSTACLE_NUM+1)-1:0]  obstacle_on_id,
  output logic [SCREEN_WIDTH-1:0]            obstacle_x_rom,
  output logic [SCREEN_WIDTH-1:0]            obstacle_y_rom,
  output logic [PHY_WIDTH-1:0]               obstacle_abs_pos_x,
  output logic [PHY_WIDTH-1:0]               obstacle_abs_pos_y,
  output logic                               scan_busy,
  output logic                               slot_overflow
);

  localparam int IDX_W  = $clog2(OBSTACLE_NUM);
  localparam int ID_W   = $clog2(OBSTACLE_NUM + 1);
  localparam int CNT_W  = $clog2(LINE_SLOTS + 1);
  localparam int SLOT_W = (LINE_SLOTS > 1) ? $clog2(LINE_SLOTS) : 1;

  localparam logic [PHY_WIDTH-1:0] Y_SPAN   = PHY_WIDTH'(2 * OBSTACLE_WIDTH);
  localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(OBSTACLE_NUM - 1);
  localparam logic [IDX_W:0]       TAB_LEN  = (IDX_W + 1)'(OBSTACLE_NUM);
  localparam logic [CNT_W-1:0]     SLOT_MAX = CNT_W'(LINE_SLOTS);

  typedef struct packed {
    logic                    vld;
    logic [ID_W-1:0]         id;
    logic [PHY_WIDTH-1:0]    abs_x;
    logic [PHY_WIDTH-1:0]    abs_y;
    logic [SCREEN_WIDTH:0]   x_end;
    logic [SCREEN_WIDTH-1:0] y_rom;
  } slot_t;

  typedef enum logic [1:0] {IDLE, SCAN, READY} state_t;

  state_t state, state_nxt;

  logic [OBSTACLE_NUM-1:0]    tab_valid;
  logic [PHY_WIDTH-1:0]       tab_x   [OBSTACLE_NUM];
  logic [PHY_WIDTH-1:0]       tab_y   [OBSTACLE_NUM];
  logic [BLOCK_LEN_WIDTH-1:0] tab_len [OBSTACLE_NUM];

  logic [IDX_W-1:0]        idx;
  logic [SCREEN_WIDTH-1:0] line_r;
  logic [PHY_WIDTH-1:0]    cam_r;
  slot_t                   slots [LINE_SLOTS];
  logic [CNT_W-1:0]        slot_cnt;

  logic [PHY_WIDTH-1:0]    scan_d;
  logic                    scan_hit;
  logic [SCREEN_WIDTH-1:0] slot_dx [LINE_SLOTS];
  logic                    sel_hit;
  logic [SLOT_W-1:0]       sel_idx;
  logic [SCREEN_WIDTH-1:0] sel_dx;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      tab_valid <= '0;
    end else if (wr_en && ({1'b0, wr_idx} < TAB_LEN)) begin
      tab_valid[wr_idx] <= wr_valid;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (wr_en && ({1'b0, wr_idx} < TAB_LEN)) begin
      tab_x[wr_idx]   <= wr_abs_x;
      tab_y[wr_idx]   <= wr_abs_y;
      tab_len[wr_idx] <= wr_len;
    end
  end

  // Modular distance below the entry's top row; wrapped world coordinates need no special case.
  assign scan_d   = cam_r + PHY_WIDTH'(line_r) - tab_y[idx];
  assign scan_hit = (state == SCAN) && tab_valid[idx] && (tab_len[idx] != '0) && (scan_d < Y_SPAN);
  assign scan_busy = (state == SCAN);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = IDLE;
      SCAN:    if (idx == LAST_IDX) state_nxt = READY;
      READY:   state_nxt = READY;
      default: state_nxt = IDLE;
    endcase
    if (line_start) state_nxt = SCAN;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state         <= IDLE;
      idx           <= '0;
      line_r        <= '0;
      cam_r         <= '0;
      slot_cnt      <= '0;
      slot_overflow <= 1'b0;
      for (int s = 0; s < LINE_SLOTS; s++) slots[s] <= '0;
    end else begin
      state <= state_nxt;
      if (line_start) begin
        line_r   <= next_line;
        cam_r    <= camera_y;
        idx      <= '0;
        slot_cnt <= '0;
        for (int s = 0; s < LINE_SLOTS; s++) slots[s] <= '0;
      end else if (state == SCAN) begin
        if (idx != LAST_IDX) idx <= idx + 1'b1;
        if (scan_hit) begin
          if (slot_cnt < SLOT_MAX) begin
            for (int s = 0; s < LINE_SLOTS; s++) begin
              if (CNT_W'(s) == slot_cnt) begin
                slots[s].vld   <= 1'b1;
                slots[s].id    <= ID_W'(idx) + ID_W'(1);
                slots[s].abs_x <= tab_x[idx];
                slots[s].abs_y <= tab_y[idx];
                slots[s].x_end <= (SCREEN_WIDTH + 1)'(tab_len[idx]) * (SCREEN_WIDTH + 1)'(OBSTACLE_WIDTH);
                slots[s].y_rom <= scan_d[SCREEN_WIDTH-1:0];
              end
            end
            slot_cnt <= slot_cnt + 1'b1;
          end else begin
            slot_overflow <= 1'b1;
          end
        end
      end
    end
  end

  for (genvar g = 0; g < LINE_SLOTS; g++) begin : g_dx
    assign slot_dx[g] = pixel_x - slots[g].abs_x[SCREEN_WIDTH-1:0];
  end

  // Walk downwards so the lowest slot (lowest table index) overrides the rest.
  always_comb begin
    sel_hit = 1'b0;
    sel_idx = '0;
    sel_dx  = '0;
    for (int s = LINE_SLOTS - 1; s >= 0; s--) begin
      if (slots[s].vld && ({1'b0, slot_dx[s]} < slots[s].x_end)) begin
        sel_hit = 1'b1;
        sel_idx = SLOT_W'(s);
        sel_dx  = slot_dx[s];
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst || !(sel_hit && pixel_active && (state == READY))) begin
      obstacle_on        <= 1'b0;
      obstacle_on_id     <= '0;
      obstacle_x_rom     <= '0;
      obstacle_y_rom     <= '0;
      obstacle_abs_pos_x <= '0;
      obstacle_abs_pos_y <= '0;
    end else begin
      obstacle_on        <= 1'b1;
      obstacle_on_id     <= slots[sel_idx].id;
      obstacle_x_rom     <= sel_dx;
      obstacle_y_rom     <= slots[sel_idx].y_rom;
      obstacle_abs_pos_x <= slots[sel_idx].abs_x;
      obstacle_abs_pos_y <= slots[sel_idx].abs_y;
    end
  end

endmodule

// File: tb/tb_obstacle_line_locator.sv
// Directed bench for obstacle_line_locator: scan latency, pixel matching, priority, wrap and mid-scan events.
module tb_obstacle_line_locator;

  logic        sys_clk;
  logic        sys_rst;
  logic        wr_en;
  logic [2:0]  wr_idx;
  logic        wr_valid;
  logic [14:0] wr_abs_x;
  logic [14:0] wr_abs_y;
  logic [3:0]  wr_len;
  logic [14:0] camera_y;
  logic        line_start;
  logic [9:0]  next_line;
  logic [9:0]  pixel_x;
  logic        pixel_active;
  logic        obstacle_on;
  logic [2:0]  obstacle_on_id;
  logic [9:0]  obstacle_x_rom;
  logic [9:0]  obstacle_y_rom;
  logic [14:0] obstacle_abs_pos_x;
  logic [14:0] obstacle_abs_pos_y;
  logic        scan_busy;
  logic        slot_overflow;

  int n_tests = 0;
  int n_fail  = 0;

  obstacle_line_locator dut (
    .sys_clk            (sys_clk),
    .sys_rst            (sys_rst),
    .wr_en              (wr_en),
    .wr_idx             (wr_idx),
    .wr_valid           (wr_valid),
    .wr_abs_x           (wr_abs_x),
    .wr_abs_y           (wr_abs_y),
    .wr_len             (wr_len),
    .camera_y           (camera_y),
    .line_start         (line_start),
    .next_line          (next_line),
    .pixel_x            (pixel_x),
    .pixel_active       (pixel_active),
    .obstacle_on        (obstacle_on),
    .obstacle_on_id     (obstacle_on_id),
    .obstacle_x_rom     (obstacle_x_rom),
    .obstacle_y_rom     (obstacle_y_rom),
    .obstacle_abs_pos_x (obstacle_abs_pos_x),
    .obstacle_abs_pos_y (obstacle_abs_pos_y),
    .scan_busy          (scan_busy),
    .slot_overflow      (slot_overflow)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic do_reset();
    sys_rst = 1'b1;
    tick();
    tick();
    sys_rst = 1'b0;
  endtask

  task automatic write_entry(input int idx, input logic vld, input int x, input int y, input int len);
    wr_en    = 1'b1;
    wr_idx   = 3'(idx);
    wr_valid = vld;
    wr_abs_x = 15'(x);
    wr_abs_y = 15'(y);
    wr_len   = 4'(len);
    tick();
    wr_en = 1'b0;
  endtask

  // Pulses line_start, then counts SCAN cycles (bounded) until READY.
  task automatic start_line(input string tag, input int line, input int cam);
    int busy_cnt;
    line_start = 1'b1;
    next_line  = 10'(line);
    camera_y   = 15'(cam);
    tick();
    line_start = 1'b0;
    busy_cnt = 0;
    for (int k = 0; k < 20 && scan_busy; k++) begin
      busy_cnt++;
      tick();
    end
    check({tag, ".busy_len"}, busy_cnt, 7);
  endtask

  task automatic pix(input string tag, input int px, input logic act, input logic on, input int id,
                     input int xr, input int yr, input int ax, input int ay);
    pixel_x      = 10'(px);
    pixel_active = act;
    tick();
    check({tag, ".on"},    obstacle_on,        32'(on));
    check({tag, ".id"},    obstacle_on_id,     id);
    check({tag, ".x_rom"}, obstacle_x_rom,     xr);
    check({tag, ".y_rom"}, obstacle_y_rom,     yr);
    check({tag, ".abs_x"}, obstacle_abs_pos_x, ax);
    check({tag, ".abs_y"}, obstacle_abs_pos_y, ay);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, ".on"},       obstacle_on,        0);
    check({tag, ".id"},       obstacle_on_id,     0);
    check({tag, ".x_rom"},    obstacle_x_rom,     0);
    check({tag, ".y_rom"},    obstacle_y_rom,     0);
    check({tag, ".abs_x"},    obstacle_abs_pos_x, 0);
    check({tag, ".abs_y"},    obstacle_abs_pos_y, 0);
    check({tag, ".busy"},     scan_busy,          0);
    check({tag, ".overflow"}, slot_overflow,      0);
  endtask

  initial begin
    sys_rst = 1'b0; wr_en = 1'b0; wr_idx = '0; wr_valid = 1'b0;
    wr_abs_x = '0; wr_abs_y = '0; wr_len = '0; camera_y = '0;
    line_start = 1'b0; next_line = '0; pixel_x = '0; pixel_active = 1'b0;

    // Reset state
    do_reset();
    check_idle_outputs("reset");

    // Single obstacle, full sweep on row 55 (y_rom 5)
    write_entry(0, 1'b1, 100, 50, 2);
    start_line("single", 55, 0);
    for (int x = 0; x < 640; x++) begin
      if (x >= 100 && x <= 119)
        pix($sformatf("sweep%0d", x), x, 1'b1, 1'b1, 1, x - 100, 5, 100, 50);
      else
        pix($sformatf("sweep%0d", x), x, 1'b1, 1'b0, 0, 0, 0, 0, 0);
    end
    pix("inactive", 105, 1'b0, 1'b0, 0, 0, 0, 0, 0);

    // Vertical edges: rows 50 and 69 hit, 49 and 70 do not
    start_line("row49", 49, 0);
    pix("row49", 105, 1'b1, 1'b0, 0, 0, 0, 0, 0);
    start_line("row50", 50, 0);
    pix("row50", 105, 1'b1, 1'b1, 1, 5, 0, 100, 50);
    start_line("row69", 69, 0);
    pix("row69", 119, 1'b1, 1'b1, 1, 19, 19, 100, 50);
    start_line("row70", 70, 0);
    pix("row70", 105, 1'b1, 1'b0, 0, 0, 0, 0, 0);

    // Overlap priority and slot overflow
    do_reset();
    for (int i = 0; i < 5; i++) write_entry(i, 1'b1, 200, 0, 1);
    start_line("overlap", 0, 0);
    check("overlap.overflow", slot_overflow, 1);
    pix("ovl199", 199, 1'b1, 1'b0, 0, 0, 0, 0, 0);
    pix("ovl200", 200, 1'b1, 1'b1, 1, 0, 0, 200, 0);
    pix("ovl209", 209, 1'b1, 1'b1, 1, 9, 0, 200, 0);
    pix("ovl210", 210, 1'b1, 1'b0, 0, 0, 0, 0, 0);
    start_line("overlap2", 100, 0);
    check("overflow_sticky", slot_overflow, 1);

    // Camera wrap, screen-x wrap and zero-length entry
    do_reset();
    check("overflow_cleared", slot_overflow, 0);
    write_entry(0, 1'b1, 300, 2, 3);
    write_entry(1, 1'b1, 1020, 2, 1);
    write_entry(2, 1'b1, 400, 2, 0);
    start_line("wrap3", 3, 32766);
    pix("wrap3_x300", 300, 1'b1, 1'b0, 0, 0, 0, 0, 0);
    pix("wrap3_x3", 3, 1'b1, 1'b0, 0, 0, 0, 0, 0);
    start_line("wrap5", 5, 32766);
    pix("wrap5_x329", 329, 1'b1, 1'b1, 1, 29, 1, 300, 2);
    pix("wrap5_x330", 330, 1'b1, 1'b0, 0, 0, 0, 0, 0);
    pix("wrap5_x1023", 1023, 1'b1, 1'b1, 2, 3, 1, 1020, 2);
    pix("wrap5_x3", 3, 1'b1, 1'b1, 2, 7, 1, 1020, 2);
    pix("wrap5_x6", 6, 1'b1, 1'b0, 0, 0, 0, 0, 0);
    pix("len0_x400", 400, 1'b1, 1'b0, 0, 0, 0, 0, 0);

    // Restart during scan relatches the new line
    do_reset();
    write_entry(0, 1'b1, 100, 50, 2);
    line_start = 1'b1; next_line = 10'd10; camera_y = '0;
    tick();
    line_start = 1'b0;
    tick();
    tick();
    start_line("restart", 52, 0);
    pix("restart_x100", 100, 1'b1, 1'b1, 1, 0, 2, 100, 50);

    // Reset in scan cycle 2 clears FSM, outputs and table
    line_start = 1'b1; next_line = 10'd52;
    tick();
    line_start = 1'b0;
    tick();
    check("midscan.busy_before", scan_busy, 1);
    sys_rst = 1'b1;
    tick();
    sys_rst = 1'b0;
    check_idle_outputs("midscan_rst");
    start_line("after_rst", 52, 0);
    pix("after_rst_x100", 100, 1'b1, 1'b0, 0, 0, 0, 0, 0);

    // Table writes during scan: entry 5 is still ahead of the scan, entry 0 is behind it
    do_reset();
    line_start = 1'b1; next_line = 10'd0; camera_y = '0;
    tick();
    line_start = 1'b0;
    tick();
    wr_en = 1'b1; wr_idx = 3'd5; wr_valid = 1'b1; wr_abs_x = 15'd500; wr_abs_y = 15'd0; wr_len = 4'd1;
    tick();
    wr_idx = 3'd0; wr_abs_x = 15'd100;
    tick();
    wr_en = 1'b0;
    for (int k = 0; k < 20 && scan_busy; k++) tick();
    check("wscan.ready", scan_busy, 0);
    pix("wscan_e5", 505, 1'b1, 1'b1, 6, 5, 0, 500, 0);
    pix("wscan_e0", 105, 1'b1, 1'b0, 0, 0, 0, 0, 0);
    start_line("wscan_next", 0, 0);
    pix("wnext_e0", 105, 1'b1, 1'b1, 1, 5, 0, 100, 0);
    pix("wnext_e5", 509, 1'b1, 1'b1, 6, 9, 0, 500, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
